bpm_link_arbiter: RTL and testbench

Merges the two BPM Aurora receive streams (CCW and CW) into a single AXI-Stream feeding the FOFB packet consumer. Each link has no backpressure, so every input gets a packet buffer with commit/rollback. Only whole, accepted packets are ever presented downstream. A packet-level round-robin arbiter shares the single output between the two buffers and tags each packet with its source link.

---
 rtl/bpm_link_arbiter_pkg.sv | 11 +
 rtl/bpm_link_arbiter_pkt_fifo.sv | 60 ++++++
 rtl/bpm_link_arbiter.sv | 63 ++++++
 tb/tb_bpm_link_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_link_arbiter_pkg.sv
// bpm_pkg: shared constants, source codes and arbiter state encoding for bpm_link_arbiter
package bpm_pkg;
  localparam logic [15:0] MAGIC = 16'hA5BE;
  localparam int PKT_SIZE_WORDS = 5;
  localparam logic SRC_CCW = 1'b0;
  localparam logic SRC_CW = 1'b1;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t SEND_CCW = 2'd1;
  localparam arb_state_t SEND_CW = 2'd2;
endpackage

// File: rtl/bpm_link_arbiter_pkt_fifo.sv
// bpm_pkt_fifo: per-link packet buffer with commit/rollback, drop counting and read port
// Ports: clk/rst; in_data/in_last/in_valid link beats (no backpressure); pop advances the
// read pointer; rd_data/rd_last show the word at rd_ptr; pending = committed packet waiting;
// clear_counts zeroes drop_cnt. Optional header check under BPM_ARB_MAGIC_CHECK_EN.
module bpm_pkt_fifo
  import bpm_pkg::*;
#(
  parameter int AW = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             in_valid,
  input  logic             pop,
  input  logic             clear_counts,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  output logic             pending,
  output logic [CNT_W-1:0] drop_cnt
);
  logic [32:0] mem [2**AW];
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
  logic bad, full, hdr_bad, take, drop_last;
  assign full = (wr_ptr - rd_ptr) == {1'b1, {AW{1'b0}}};
`ifdef BPM_ARB_MAGIC_CHECK_EN
  logic sop;
  assign hdr_bad = sop && in_data[31:16] != MAGIC;
  always_ff @(posedge clk)
    if (rst) sop <= 1'b1;
    else if (in_valid) sop <= in_last;
`else
  assign hdr_bad = 1'b0;
`endif
  assign take = in_valid && !(bad || full || hdr_bad);
  assign drop_last = in_valid && in_last && !take;
  assign pending = commit_ptr != rd_ptr;
  assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (take) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  // bad clears on every tlast so the next packet starts clean
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      bad <= 1'b0;
    end else begin
      if (take) wr_ptr <= wr_ptr + 1'b1;
      else if (drop_last) wr_ptr <= commit_ptr;
      if (take && in_last) commit_ptr <= wr_ptr + 1'b1;
      if (in_valid) bad <= !in_last && !take;
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk)
    if (rst || clear_counts) drop_cnt <= '0;
    else if (drop_last && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
endmodule

// File: rtl/bpm_link_arbiter.sv
// bpm_link_arbiter: merges CCW/CW BPM streams into one AXI-Stream with packet round-robin
// Ports: clk/rst; BPM_CCW_/BPM_CW_AXI_STREAM_RX_* link inputs (no tready); m_* merged
// output, m_tuser = source (0 CCW, 1 CW); clear_counts, drop_ccw_cnt/drop_cw_cnt drop counters.
// Define BPM_ARB_MAGIC_CHECK_EN to drop packets whose first word lacks the magic header.
module bpm_link_arbiter
  import bpm_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      BPM_CCW_AXI_STREAM_RX_tdata,
  input  logic             BPM_CCW_AXI_STREAM_RX_tlast,
  input  logic             BPM_CCW_AXI_STREAM_RX_tvalid,
  input  logic [31:0]      BPM_CW_AXI_STREAM_RX_tdata,
  input  logic             BPM_CW_AXI_STREAM_RX_tlast,
  input  logic             BPM_CW_AXI_STREAM_RX_tvalid,
  output logic [31:0]      m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] drop_ccw_cnt,
  output logic [CNT_W-1:0] drop_cw_cnt
);
  logic [31:0] data_ccw, data_cw;
  logic last_ccw, last_cw, pend_ccw, pend_cw, fire, last_grant;
  arb_state_t state;
  assign m_tvalid = state == SEND_CCW || state == SEND_CW;
  assign m_tuser = state == SEND_CW;
  assign m_tdata = state == SEND_CCW ? data_ccw : state == SEND_CW ? data_cw : '0;
  assign m_tlast = state == SEND_CCW ? last_ccw : state == SEND_CW ? last_cw : 1'b0;
  assign fire = m_tvalid && m_tready;
  bpm_pkt_fifo #(.AW(FIFO_AW), .CNT_W(CNT_W)) u_ccw (
    .clk(clk), .rst(rst),
    .in_data(BPM_CCW_AXI_STREAM_RX_tdata), .in_last(BPM_CCW_AXI_STREAM_RX_tlast),
    .in_valid(BPM_CCW_AXI_STREAM_RX_tvalid), .pop(fire && state == SEND_CCW),
    .clear_counts(clear_counts), .rd_data(data_ccw), .rd_last(last_ccw),
    .pending(pend_ccw), .drop_cnt(drop_ccw_cnt)
  );
  bpm_pkt_fifo #(.AW(FIFO_AW), .CNT_W(CNT_W)) u_cw (
    .clk(clk), .rst(rst),
    .in_data(BPM_CW_AXI_STREAM_RX_tdata), .in_last(BPM_CW_AXI_STREAM_RX_tlast),
    .in_valid(BPM_CW_AXI_STREAM_RX_tvalid), .pop(fire && state == SEND_CW),
    .clear_counts(clear_counts), .rd_data(data_cw), .rd_last(last_cw),
    .pending(pend_cw), .drop_cnt(drop_cw_cnt)
  );
  // on a tie the link not served last wins; last_grant starts at CW so CCW goes first
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= SRC_CW;
    end else if (state == IDLE) begin
      if (pend_ccw && (!pend_cw || last_grant == SRC_CW)) state <= SEND_CCW;
      else if (pend_cw) state <= SEND_CW;
    end else if (fire && m_tlast) begin
      state <= IDLE;
      last_grant <= m_tuser;
    end
  end
endmodule

// File: tb/tb_bpm_link_arbiter.sv
// tb_bpm_link_arbiter: directed table-driven checks of bpm_link_arbiter
module tb_bpm_link_arbiter;
  import bpm_pkg::*;
`ifdef BPM_ARB_MAGIC_CHECK_EN
  localparam int MAGIC_ON = 1;
`else
  localparam int MAGIC_ON = 0;
`endif
  logic clk = 0, rst = 1;
  logic [31:0] ccw_data = 0, cw_data = 0;
  logic ccw_last = 0, ccw_valid = 0, cw_last = 0, cw_valid = 0;
  logic m_tready = 1, clear_counts = 0;
  logic [31:0] m_tdata, s_tdata;
  logic m_tlast, m_tvalid, m_tuser, s_tlast, s_tvalid, s_tuser;
  logic [15:0] drop_ccw_cnt, drop_cw_cnt;
  logic [1:0] s_dccw, s_dcw;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bpm_link_arbiter dut (
    .clk(clk), .rst(rst),
    .BPM_CCW_AXI_STREAM_RX_tdata(ccw_data), .BPM_CCW_AXI_STREAM_RX_tlast(ccw_last),
    .BPM_CCW_AXI_STREAM_RX_tvalid(ccw_valid),
    .BPM_CW_AXI_STREAM_RX_tdata(cw_data), .BPM_CW_AXI_STREAM_RX_tlast(cw_last),
    .BPM_CW_AXI_STREAM_RX_tvalid(cw_valid),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .clear_counts(clear_counts),
    .drop_ccw_cnt(drop_ccw_cnt), .drop_cw_cnt(drop_cw_cnt)
  );
  bpm_link_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .BPM_CCW_AXI_STREAM_RX_tdata(ccw_data), .BPM_CCW_AXI_STREAM_RX_tlast(ccw_last),
    .BPM_CCW_AXI_STREAM_RX_tvalid(ccw_valid),
    .BPM_CW_AXI_STREAM_RX_tdata(cw_data), .BPM_CW_AXI_STREAM_RX_tlast(cw_last),
    .BPM_CW_AXI_STREAM_RX_tvalid(cw_valid),
    .m_tdata(s_tdata), .m_tlast(s_tlast), .m_tvalid(s_tvalid), .m_tready(m_tready),
    .m_tuser(s_tuser), .clear_counts(clear_counts),
    .drop_ccw_cnt(s_dccw), .drop_cw_cnt(s_dcw)
  );
  typedef struct packed {logic user; logic last; logic [31:0] data;} beat_t;
  beat_t got[$];
  logic [34:0] prev;
  logic stalled = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // output monitor: collects accepted beats and checks stability during stalls
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled) chk("stall_stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev);
      if (m_tvalid && m_tready) got.push_back({m_tuser, m_tlast, m_tdata});
      stalled = m_tvalid && !m_tready;
      prev = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    step();
    rst = 1;
    step();
    step();
    rst = 0;
    got.delete();
  endtask
  task automatic send_pkt(input int link, input logic [31:0] hdr, input int len, input bit clr_last = 0);
    for (int i = 0; i < len; i++) begin
      step();
      ccw_valid = link != 1;
      cw_valid = link != 0;
      ccw_data = hdr + i;
      cw_data = hdr + i;
      ccw_last = i == len - 1;
      cw_last = i == len - 1;
      clear_counts = clr_last && i == len - 1;
    end
    step();
    ccw_valid = 0;
    cw_valid = 0;
    ccw_last = 0;
    cw_last = 0;
    clear_counts = 0;
  endtask
  task automatic wait_beats(input int n, input int budget, input string name);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (10) @(negedge clk);
    chk(name, got.size(), n);
  endtask
  function automatic bit intact(input logic [31:0] hdr, input logic user);
    bit ok = 1;
    for (int i = 0; i < got.size(); i++)
      ok &= got[i].data == hdr + i && got[i].last == (i == got.size() - 1) && got[i].user == user;
    return ok;
  endfunction
  typedef struct {int link; logic [31:0] hdr; int len; int beats; logic user; int dccw; int dcw;} vec_t;
  vec_t vt[6];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{0, 32'hA5BE0001, PKT_SIZE_WORDS, 5, 1'b0, 0, 0};
    vt[1] = '{1, 32'hA5BE0002, PKT_SIZE_WORDS, 5, 1'b1, 0, 0};
    vt[2] = '{1, 32'h12340000, PKT_SIZE_WORDS, MAGIC_ON ? 0 : 5, 1'b1, 0, MAGIC_ON};
    vt[3] = '{0, 32'hA5BE0003, 1, 1, 1'b0, 0, MAGIC_ON};
    vt[4] = '{1, 32'hA5BE0004, 16, 16, 1'b1, 0, MAGIC_ON};
    vt[5] = '{0, 32'hA5BE0005, 17, 0, 1'b0, 1, MAGIC_ON};
    // reset state
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_dccw", drop_ccw_cnt, 0);
    chk("rst_dcw", drop_cw_cnt, 0);
    do_reset();
    // single-packet vectors
    foreach (vt[k]) begin
      got.delete();
      send_pkt(vt[k].link, vt[k].hdr, vt[k].len);
      wait_beats(vt[k].beats, 60, $sformatf("vec%0d_beats", k));
      if (vt[k].beats > 0 && got.size() > 0) begin
        chk($sformatf("vec%0d_hdr", k), got[0].data, vt[k].hdr);
        chk($sformatf("vec%0d_user", k), got[0].user, vt[k].user);
        chk($sformatf("vec%0d_intact", k), intact(vt[k].hdr, vt[k].user), 1);
      end
      chk($sformatf("vec%0d_dccw", k), drop_ccw_cnt, vt[k].dccw);
      chk($sformatf("vec%0d_dcw", k), drop_cw_cnt, vt[k].dcw);
    end
    // CCW only, 8 packets
    do_reset();
    for (int p = 0; p < 8; p++) send_pkt(0, 32'hA5BE8000 + p, 5);
    wait_beats(40, 200, "ccw8_beats");
    if (got.size() >= 40)
      for (int p = 0; p < 8; p++) begin
        chk($sformatf("ccw8_hdr%0d", p), got[5*p].data, 32'hA5BE8000 + p);
        chk($sformatf("ccw8_user%0d", p), got[5*p+4].user, 0);
      end
    chk("ccw8_dccw", drop_ccw_cnt, 0);
    // identical packets on both links: alternate CCW/CW
    do_reset();
    for (int p = 0; p < 8; p++) begin
      send_pkt(2, 32'hA5BE9000 + 16 * p, 5);
      repeat (8) step();
    end
    wait_beats(80, 300, "tie_beats");
    if (got.size() >= 80)
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("tie_user%0d", k), got[5*k].user, k % 2);
        chk($sformatf("tie_hdr%0d", k), got[5*k].data, 32'hA5BE9000 + 16 * (k / 2));
      end
    chk("tie_dccw", drop_ccw_cnt, 0);
    chk("tie_dcw", drop_cw_cnt, 0);
    // backpressure: fourth packet overflows
    do_reset();
    m_tready = 0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(0, 32'hA5BEA000 + 16 * p, 5);
      step();
    end
    @(negedge clk);
    chk("bp_dccw", drop_ccw_cnt, 1);
    chk("bp_none_out", got.size(), 0);
    step();
    m_tready = 1;
    wait_beats(15, 100, "bp_beats");
    if (got.size() >= 15)
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("bp_hdr%0d", p), got[5*p].data, 32'hA5BEA000 + 16 * p);
        chk($sformatf("bp_last%0d", p), got[5*p+4].last, 1);
      end
    // reset in the middle of an input packet
    do_reset();
    step();
    ccw_valid = 1;
    ccw_data = 32'hA5BEB000;
    step();
    ccw_data = 32'hA5BEB001;
    step();
    ccw_valid = 0;
    rst = 1;
    step();
    rst = 0;
    repeat (10) step();
    chk("mid_rst_out", got.size(), 0);
    chk("mid_rst_dccw", drop_ccw_cnt, 0);
    send_pkt(0, 32'hA5BEC000, 5);
    @(negedge clk);
    chk("lat_n1_tvalid", m_tvalid, 0);
    @(negedge clk);
    chk("lat_n2_tvalid", m_tvalid, 1);
    chk("lat_n2_tdata", m_tdata, 32'hA5BEC000);
    wait_beats(5, 40, "mid_rst_beats");
    chk("mid_rst_intact", intact(32'hA5BEC000, 1'b0), 1);
    // oversize packets: saturation and clear priority
    do_reset();
    for (int p = 0; p < 5; p++) begin
      send_pkt(0, 32'hA5BED000, 17);
      step();
    end
    @(negedge clk);
    chk("sat_cnt", s_dccw, 3);
    chk("wide_cnt", drop_ccw_cnt, 5);
    send_pkt(0, 32'hA5BED000, 17, 1);
    @(negedge clk);
    chk("clr_sat_cnt", s_dccw, 0);
    chk("clr_wide_cnt", drop_ccw_cnt, 0);
    chk("oversize_out", got.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
